// File: rtl/sr_latch_bank_if.sv
// sr_latch_bank bus: enable, set/reset and flag-clear requests
// in; registered state, complement, conflict flags (and count) out.
// Optional: SR_CONFLICT_CNT_EN adds conflict_cnt.
interface sr_latch_bank_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             en;
   logic [WIDTH-1:0] S;
   logic [WIDTH-1:0] R;
   logic             clr_flag;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] Qinv;
   logic [WIDTH-1:0] conflict;
`ifdef SR_CONFLICT_CNT_EN
   logic [CNT_W-1:0] conflict_cnt;
`endif

   if (WIDTH < 1 || WIDTH > 32) begin : g_wchk
      $error("sr_latch_bank_if: WIDTH out of range");
   end
   if (CNT_W < 2 || CNT_W > 16) begin : g_cchk
      $error("sr_latch_bank_if: CNT_W out of range");
   end

   modport master (
      output en, S, R, clr_flag,
      input  Q, Qinv, conflict
`ifdef SR_CONFLICT_CNT_EN
      , input conflict_cnt
`endif
   );

   modport slave (
      input  en, S, R, clr_flag,
      output Q, Qinv, conflict
`ifdef SR_CONFLICT_CNT_EN
      , output conflict_cnt
`endif
   );
endinterface

// File: rtl/sr_latch_bank.sv
// Bank of WIDTH clocked SR channels with sticky conflict flags.
// Ports: clk, rst (sync, active-high), bus (sr_latch_bank_if.slave).
// Optional: SR_CONFLICT_CNT_EN adds a saturating conflict counter.
module sr_latch_bank #(
   parameter int WIDTH = 8,
   parameter int MODE  = 0,
   parameter int CNT_W = 8
) (
   input logic            clk,
   input logic            rst,
   sr_latch_bank_if.slave bus
);
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qinv;
   logic [WIDTH-1:0] conf;
   logic [WIDTH-1:0] q_n;
   logic [WIDTH-1:0] conf_n;
   logic [WIDTH-1:0] both;
   logic [WIDTH-1:0] res;

   if (WIDTH < 1 || WIDTH > 32) begin : g_wchk
      $error("sr_latch_bank: WIDTH out of range");
   end
   if (CNT_W < 2 || CNT_W > 16) begin : g_cchk
      $error("sr_latch_bank: CNT_W out of range");
   end

   assign both = bus.S & bus.R;

   // Value taken by a channel that sees S=R=1.
   // Unknown MODE values fall back to hold.
   always_comb begin
      res = q;
      unique case (1'b1)
         (MODE == 0): res = '1;
         (MODE == 1): res = '0;
         (MODE == 3): res = ~q;
         default:     res = q;
      endcase
   end

   always_comb begin
      q_n = (q & ~bus.S & ~bus.R)
          | (bus.S & ~bus.R)
          | (both & res);
      // A fresh conflict beats a clear on the same edge.
      conf_n = (bus.clr_flag ? '0 : conf) | both;
   end

   // Qinv is its own register so it never lags Q.
   always_ff @(posedge clk) begin
      if (rst) begin
         q    <= '0;
         qinv <= '1;
         conf <= '0;
      end else if (bus.en) begin
         q    <= q_n;
         qinv <= ~q_n;
         conf <= conf_n;
      end
   end

   assign bus.Q        = q;
   assign bus.Qinv     = qinv;
   assign bus.conflict = conf;

`ifdef SR_CONFLICT_CNT_EN
   logic [CNT_W-1:0] cnt;

   // One count per conflicting cycle; clr_flag leaves it alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (bus.en && (|both) && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bus.conflict_cnt = cnt;
`endif
endmodule

// File: tb/tb_sr_latch_bank.sv
// Bench for sr_latch_bank: five instances (MODE 0,1,2,3,7),
// table vectors plus hand sequences, queue-based scoreboard.
module tb_sr_latch_bank;
   localparam int ND = 5;
   localparam int MODES [ND] = '{0, 1, 2, 3, 7};

   logic       clk = 1'b0;
   logic       rst_d;
   logic       en_d;
   logic [7:0] s_d;
   logic [7:0] r_d;
   logic       clr_d;

   logic [7:0] q_a  [ND];
   logic [7:0] qi_a [ND];
   logic [7:0] cf_a [ND];
   logic [1:0] cnt_a[ND];

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : gd
      sr_latch_bank_if #(.WIDTH(8), .CNT_W(2)) bus ();
      assign bus.en       = en_d;
      assign bus.S        = s_d;
      assign bus.R        = r_d;
      assign bus.clr_flag = clr_d;
      assign q_a[g]  = bus.Q;
      assign qi_a[g] = bus.Qinv;
      assign cf_a[g] = bus.conflict;
`ifdef SR_CONFLICT_CNT_EN
      assign cnt_a[g] = bus.conflict_cnt;
`else
      assign cnt_a[g] = 2'b00;
`endif
      sr_latch_bank #(
         .WIDTH(8), .MODE(MODES[g]), .CNT_W(2)
      ) dut (
         .clk(clk),
         .rst(rst_d),
         .bus(bus)
      );
   end

   typedef struct {
      bit         rst;
      bit         en;
      logic [7:0] s;
      logic [7:0] r;
      bit         clr;
      logic [7:0] q;
      logic [7:0] cf;
      logic [1:0] cnt;
   } vec_t;

   typedef struct {
      int         d;
      string      nm;
      logic [7:0] q;
      logic [7:0] cf;
      logic [1:0] cnt;
      bit         ccnt;
   } exp_t;

   vec_t tab[14];
   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %h want %h", nm, act, exp);
      else
         passed++;
   endtask

   task automatic drive(bit rs, bit e, logic [7:0] s,
                        logic [7:0] r, bit c);
      rst_d = rs;
      en_d  = e;
      s_d   = s;
      r_d   = r;
      clr_d = c;
   endtask

   task automatic push(int d, string nm, logic [7:0] q,
                       logic [7:0] cf, logic [1:0] cnt, bit cc);
      exp_t e;
      e.d = d; e.nm = nm; e.q = q;
      e.cf = cf; e.cnt = cnt; e.ccnt = cc;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk({e.nm, ".q"},    q_a[e.d],  e.q);
         chk({e.nm, ".qinv"}, qi_a[e.d], ~e.q);
         chk({e.nm, ".conf"}, cf_a[e.d], e.cf);
`ifdef SR_CONFLICT_CNT_EN
         if (e.ccnt)
            chk({e.nm, ".cnt"}, {6'd0, cnt_a[e.d]},
                {6'd0, e.cnt});
`endif
      end
   endtask

   initial begin
      // rst en S R clr | Q conf cnt  (MODE 0 instance)
      tab[0]  = '{1, 0, 8'hFF, 8'hFF, 0, 8'h00, 8'h00, 2'd0};
      tab[1]  = '{0, 1, 8'h0F, 8'h00, 0, 8'h0F, 8'h00, 2'd0};
      tab[2]  = '{0, 1, 8'h00, 8'h03, 0, 8'h0C, 8'h00, 2'd0};
      tab[3]  = '{0, 1, 8'hAA, 8'h55, 0, 8'hAA, 8'h00, 2'd0};
      tab[4]  = '{0, 0, 8'h55, 8'hAA, 0, 8'hAA, 8'h00, 2'd0};
      tab[5]  = '{0, 0, 8'h55, 8'hAA, 1, 8'hAA, 8'h00, 2'd0};
      tab[6]  = '{0, 0, 8'h55, 8'hAA, 0, 8'hAA, 8'h00, 2'd0};
      tab[7]  = '{0, 1, 8'h55, 8'hAA, 0, 8'h55, 8'h00, 2'd0};
      tab[8]  = '{0, 1, 8'h01, 8'h01, 0, 8'h55, 8'h01, 2'd1};
      tab[9]  = '{0, 1, 8'h02, 8'h02, 1, 8'h57, 8'h02, 2'd2};
      tab[10] = '{0, 1, 8'h00, 8'h00, 1, 8'h57, 8'h00, 2'd2};
      tab[11] = '{0, 0, 8'hFF, 8'hFF, 0, 8'h57, 8'h00, 2'd2};
      tab[12] = '{1, 1, 8'hFF, 8'hFF, 1, 8'h00, 8'h00, 2'd0};
      tab[13] = '{0, 1, 8'h80, 8'h00, 0, 8'h80, 8'h00, 2'd0};

      drive(1, 0, 8'h00, 8'h00, 0);
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         drive(tab[i].rst, tab[i].en, tab[i].s,
               tab[i].r, tab[i].clr);
         push(0, $sformatf("vec%0d", i), tab[i].q,
              tab[i].cf, tab[i].cnt, 1);
         tick();
      end

      // S=R=1 resolution for every MODE (7 acts as hold).
      drive(1, 1, 8'h00, 8'h00, 0);
      tick();
      drive(0, 1, 8'h00, 8'hFF, 0);
      tick();
      drive(0, 1, 8'hFF, 8'h00, 0);
      for (int d = 0; d < ND; d++)
         push(d, $sformatf("pre_m%0d", MODES[d]),
              8'hFF, 8'h00, 2'd0, 0);
      tick();
      drive(0, 1, 8'hFF, 8'hFF, 0);
      push(0, "m0c1", 8'hFF, 8'hFF, 2'd0, 0);
      push(1, "m1c1", 8'h00, 8'hFF, 2'd0, 0);
      push(2, "m2c1", 8'hFF, 8'hFF, 2'd0, 0);
      push(3, "m3c1", 8'h00, 8'hFF, 2'd0, 0);
      push(4, "m7c1", 8'hFF, 8'hFF, 2'd0, 0);
      tick();
      push(0, "m0c2", 8'hFF, 8'hFF, 2'd0, 0);
      push(1, "m1c2", 8'h00, 8'hFF, 2'd0, 0);
      push(2, "m2c2", 8'hFF, 8'hFF, 2'd0, 0);
      push(3, "m3c2", 8'hFF, 8'hFF, 2'd0, 0);
      push(4, "m7c2", 8'hFF, 8'hFF, 2'd0, 0);
      tick();

      // Counter saturation on MODE 0 instance.
      drive(1, 1, 8'h00, 8'h00, 0);
      push(0, "cnt_rst", 8'h00, 8'h00, 2'd0, 1);
      tick();
      for (int k = 0; k < 5; k++) begin
         drive(0, 1, 8'h07, 8'h07, 0);
         push(0, $sformatf("cnt%0d", k), 8'h07, 8'h07,
              (k < 3) ? 2'(k + 1) : 2'd3, 1);
         tick();
      end
      drive(0, 1, 8'h00, 8'h00, 1);
      push(0, "cnt_clr", 8'h07, 8'h00, 2'd3, 1);
      tick();
      drive(1, 0, 8'h00, 8'h00, 0);
      push(0, "cnt_rst2", 8'h00, 8'h00, 2'd0, 1);
      tick();

      // Reset in the middle of MODE 3 toggling.
      drive(0, 1, 8'hFF, 8'hFF, 0);
      push(3, "tg1", 8'hFF, 8'hFF, 2'd0, 0);
      tick();
      push(3, "tg2", 8'h00, 8'hFF, 2'd0, 0);
      tick();
      push(3, "tg3", 8'hFF, 8'hFF, 2'd0, 0);
      tick();
      rst_d = 1'b1;
      push(3, "tg_rst", 8'h00, 8'h00, 2'd0, 0);
      tick();
      rst_d = 1'b0;
      push(3, "tg_resume", 8'hFF, 8'hFF, 2'd0, 0);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
